// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_ctrl
// Brief   : Instruction-fetch front end feeding the IF/ID register; optional
//           performance counters when FETCH_PERF_CNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_incr,
    output logic [31:0] instr,
    output logic [25:0] jumpoffset,
    output logic        out_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] discard_count
`endif
);

    localparam logic [31:0] c_pc_step = 32'(PC_STEP);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_pc_pending, w_pc_pending_nxt;
    logic [31:0] r_buf_pc_incr, w_buf_pc_incr_nxt;
    logic [31:0] r_buf_instr, w_buf_instr_nxt;
    logic [31:0] r_pc_incr, w_pc_incr_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic        w_load;
    logic        w_discard;
    logic [31:0] w_pc_plus;
    logic [31:0] w_redirect_pc;
    logic        w_slot_free;

    assign w_pc_plus     = r_pc + c_pc_step;
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_slot_free   = !stall || !r_out_valid;

    // DRAIN keeps requesting the old pc so the handshake is never abandoned.
    assign imem_req   = !rst && (r_state == ST_FETCH || r_state == ST_DRAIN);
    assign imem_addr  = r_pc;
    assign pc_incr    = r_pc_incr;
    assign instr      = r_instr;
    assign jumpoffset = r_instr[25:0];
    assign out_valid  = r_out_valid;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pc_pending_nxt  = r_pc_pending;
        w_buf_pc_incr_nxt = r_buf_pc_incr;
        w_buf_instr_nxt   = r_buf_instr;
        w_pc_incr_nxt     = r_pc_incr;
        w_instr_nxt       = r_instr;
        w_out_valid_nxt   = r_out_valid;
        w_load            = 1'b0;
        w_discard         = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (redirect_valid) begin
                    w_out_valid_nxt = 1'b0;
                    if (imem_ack) begin
                        w_pc_nxt  = w_redirect_pc;
                        w_discard = 1'b1;
                    end else begin
                        w_pc_pending_nxt = w_redirect_pc;
                        w_state_nxt      = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    w_pc_nxt = w_pc_plus;
                    if (w_slot_free) begin
                        w_pc_incr_nxt   = w_pc_plus;
                        w_instr_nxt     = imem_rdata;
                        w_out_valid_nxt = 1'b1;
                        w_load          = 1'b1;
                    end else begin
                        w_buf_pc_incr_nxt = w_pc_plus;
                        w_buf_instr_nxt   = imem_rdata;
                        w_state_nxt       = ST_HOLD;
                    end
                end else if (!stall) begin
                    w_out_valid_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_out_valid_nxt   = 1'b0;
                    w_buf_pc_incr_nxt = 32'h0;
                    w_buf_instr_nxt   = 32'h0;
                    w_pc_nxt          = w_redirect_pc;
                    w_state_nxt       = ST_FETCH;
                end else if (!stall) begin
                    w_pc_incr_nxt   = r_buf_pc_incr;
                    w_instr_nxt     = r_buf_instr;
                    w_out_valid_nxt = 1'b1;
                    w_load          = 1'b1;
                    w_state_nxt     = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                w_out_valid_nxt = 1'b0;
                if (redirect_valid) begin
                    w_pc_pending_nxt = w_redirect_pc;
                end
                // A redirect arriving with the ack is the newest target.
                if (imem_ack) begin
                    w_pc_nxt    = redirect_valid ? w_redirect_pc : r_pc_pending;
                    w_discard   = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_pc_pending  <= 32'h0;
            r_buf_pc_incr <= 32'h0;
            r_buf_instr   <= 32'h0;
            r_pc_incr     <= 32'h0;
            r_instr       <= 32'h0;
            r_out_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pc_pending  <= w_pc_pending_nxt;
            r_buf_pc_incr <= w_buf_pc_incr_nxt;
            r_buf_instr   <= w_buf_instr_nxt;
            r_pc_incr     <= w_pc_incr_nxt;
            r_instr       <= w_instr_nxt;
            r_out_valid   <= w_out_valid_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [15:0] r_discard_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count   <= 32'h0;
            r_discard_count <= 16'h0;
        end else begin
            if (w_load) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_discard && r_discard_count != 16'hFFFF) begin
                r_discard_count <= r_discard_count + 16'd1;
            end
        end
    end

    assign fetch_count   = r_fetch_count;
    assign discard_count = r_discard_count;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = w_load ^ w_discard;
`endif

endmodule
`default_nettype wire
